// File: rtl/mbox_tx_mux_pkg.sv
// mbox_pkg: shared types and constants for the mailbox transmit engine.
//   state_t      - link FSM states
//   HDR_CH_LSB   - bit offset of the channel index inside the header word
//   HDR_SEQ_LSB  - bit offset of the sequence number inside the header word
//   SEQW         - width of the per-channel sequence counter
package mbox_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int HDR_CH_LSB  = 0;
    localparam int HDR_SEQ_LSB = 8;
    localparam int SEQW        = 8;

endpackage

// File: rtl/mbox_tx_mux_if.sv
// mbox_link_if: the outbound mailbox link.
//   mbox_w_dat/valid/ready - word handshake (valid holds with stable data until ready)
//   mbox_w_done            - 1-cycle pulse, packet finished
//   mbox_w_abort           - 1-cycle pulse, in-flight packet cancelled locally
//   mbox_r_abort           - far side cancels the in-flight packet
// master = transmit engine, slave = link consumer.
interface mbox_link_if #(parameter int DW = 32);
    logic [DW-1:0] mbox_w_dat;
    logic          mbox_w_valid;
    logic          mbox_w_ready;
    logic          mbox_w_done;
    logic          mbox_w_abort;
    logic          mbox_r_abort;

    modport master (
        output mbox_w_dat, mbox_w_valid, mbox_w_done, mbox_w_abort,
        input  mbox_w_ready, mbox_r_abort
    );

    modport slave (
        input  mbox_w_dat, mbox_w_valid, mbox_w_done, mbox_w_abort,
        output mbox_w_ready, mbox_r_abort
    );
endinterface

// File: rtl/mbox_tx_mux_chan_fifo.sv
// mbox_chan_fifo: per-channel store-and-forward FIFO of {last, dat}.
//   i_dat/i_valid/i_last/o_ready - source push side
//   i_flush  - discard everything (committed and uncommitted); beats any push
//   i_pop    - advance read pointer by one word
//   i_skip   - jump read pointer past the end of the current packet
//   i_dec    - one packet leaves (completed or skipped)
//   o_dat/o_last - head word
//   o_pkt_cnt    - number of committed packets held
//   o_drop       - 1-cycle pulse when a partial packet that cannot fit is discarded
module mbox_chan_fifo #(
    parameter int  DW    = 32,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          reset,
    input  logic [DW-1:0] i_dat,
    input  logic          i_valid,
    input  logic          i_last,
    output logic          o_ready,
    input  logic          i_flush,
    input  logic          i_pop,
    input  logic          i_skip,
    input  logic          i_dec,
    output logic [DW-1:0] o_dat,
    output logic          o_last,
    output logic [AW:0]   o_pkt_cnt,
    output logic          o_drop
);

    logic [DW:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr, r_cm_ptr, r_rd_ptr, r_pkt_cnt;
    logic        r_drop;
    logic [AW:0] w_pkt_end;
    logic        w_found, w_full, w_overflow, w_push, w_commit;

    // Full with nothing committed: the open packet can never complete here.
    assign w_full     = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
    assign w_overflow = w_full && (r_pkt_cnt == '0);
    assign o_ready    = !(w_full && (r_pkt_cnt != '0));
    assign w_push     = i_valid && o_ready && !i_flush && !w_overflow;
    assign w_commit   = w_push && i_last;

    assign o_dat     = r_mem[r_rd_ptr[AW-1:0]][DW-1:0];
    assign o_last    = r_mem[r_rd_ptr[AW-1:0]][DW];
    assign o_pkt_cnt = r_pkt_cnt;
    assign o_drop    = r_drop;

    // First last-tagged word at or after the read pointer. Only used while a
    // committed packet is at the head, so a genuine last is always found
    // before any stale bits beyond the commit pointer.
    always_comb begin
        w_pkt_end = r_rd_ptr;
        w_found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_found && r_mem[r_rd_ptr[AW-1:0] + AW'(i)][DW]) begin
                w_found   = 1'b1;
                w_pkt_end = r_rd_ptr + (AW+1)'(i + 1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_cm_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pkt_cnt <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= w_overflow && !i_flush;
            if (i_flush) begin
                r_wr_ptr  <= '0;
                r_cm_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_pkt_cnt <= '0;
            end else begin
                if (w_overflow) begin
                    r_wr_ptr <= r_cm_ptr;
                end else if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (i_last) begin
                        r_cm_ptr <= r_wr_ptr + 1'b1;
                    end
                end
                if (i_skip) begin
                    r_rd_ptr <= w_pkt_end;
                end else if (i_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_commit, i_dec})
                    2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
                    2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
                    default: r_pkt_cnt <= r_pkt_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {i_last, i_dat};
        end
    end

endmodule

// File: rtl/mbox_tx_mux.sv
// mbox_tx_mux: multi-channel mailbox transmit engine. Each source channel
// fills a private FIFO; complete packets are serialised round-robin onto one
// link, each prefixed by a header {seq[7:0], ch[7:0]}.
//   aclk, reset                  - clock, synchronous active-high reset
//   s_dat/s_valid/s_last/s_ready - per-channel source push
//   s_abort                      - per-channel flush request
//   mbox                         - outbound link (mbox_link_if.master)
//   irq_sent/irq_abort/irq_error - per-channel 1-cycle event pulses
//
// state | meaning
// IDLE  | no packet in flight, arbitrate among channels with committed packets
// HDR   | header word of granted channel on the link
// DATA  | payload words popped from granted channel
// DONE  | done pulse, seq++, packet retired; arbitrates for a back-to-back grant
module mbox_tx_mux
    import mbox_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic [NCH*DW-1:0] s_dat,
    input  logic [NCH-1:0]    s_valid,
    input  logic [NCH-1:0]    s_last,
    output logic [NCH-1:0]    s_ready,
    input  logic [NCH-1:0]    s_abort,
    mbox_link_if.master       mbox,
    output logic [NCH-1:0]    irq_sent,
    output logic [NCH-1:0]    irq_abort,
    output logic [NCH-1:0]    irq_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_gnt, r_rr_ptr, w_gnt_nx;
    logic [SEQW-1:0] r_seq [NCH];
    logic            r_w_abort;
    logic [NCH-1:0]  r_irq_abort;

    logic [DW-1:0]   w_f_dat [NCH];
    logic [AW:0]     w_pkt_cnt [NCH];
    logic [NCH-1:0]  w_f_last, w_pop, w_skip, w_dec, w_elig, w_gnt_oh, w_sent;
    logic            w_gnt_vld, w_inflight, w_loc_abort, w_far_abort;
    logic [DW-1:0]   w_hdr, w_dat;
    logic            w_valid, w_done;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        mbox_chan_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .aclk      (aclk),
            .reset     (reset),
            .i_dat     (s_dat[c*DW +: DW]),
            .i_valid   (s_valid[c]),
            .i_last    (s_last[c]),
            .o_ready   (s_ready[c]),
            .i_flush   (s_abort[c]),
            .i_pop     (w_pop[c]),
            .i_skip    (w_skip[c]),
            .i_dec     (w_dec[c]),
            .o_dat     (w_f_dat[c]),
            .o_last    (w_f_last[c]),
            .o_pkt_cnt (w_pkt_cnt[c]),
            .o_drop    (irq_error[c])
        );
    end

    assign w_inflight  = (r_state == HDR) || (r_state == DATA);
    assign w_loc_abort = w_inflight && s_abort[r_gnt];
    assign w_far_abort = w_inflight && mbox.mbox_r_abort;
    assign w_gnt_oh    = NCH'(1) << r_gnt;

    // In DONE the retiring packet is still counted, so its channel needs a
    // second packet to win the back-to-back grant.
    always_comb begin
        w_elig = '0;
        for (int c = 0; c < NCH; c++) begin
            if ((r_state == DONE) && (r_gnt == CW'(c))) begin
                w_elig[c] = !s_abort[c] && (w_pkt_cnt[c] > (AW+1)'(1));
            end else begin
                w_elig[c] = !s_abort[c] && (w_pkt_cnt[c] != '0);
            end
        end
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_nx  = r_rr_ptr;
        for (int i = 0; i < NCH; i++) begin
            if (!w_gnt_vld && w_elig[(int'(r_rr_ptr) + i) % NCH]) begin
                w_gnt_vld = 1'b1;
                w_gnt_nx  = CW'((int'(r_rr_ptr) + i) % NCH);
            end
        end
    end

    always_comb begin
        w_hdr = '0;
        w_hdr[HDR_SEQ_LSB +: SEQW] = r_seq[r_gnt];
        w_hdr[HDR_CH_LSB +: 8]     = 8'(r_gnt);
    end

    always_comb begin
        w_state_nx = r_state;
        w_pop      = '0;
        w_skip     = '0;
        w_dec      = '0;
        w_sent     = '0;
        w_valid    = 1'b0;
        w_done     = 1'b0;
        w_dat      = '0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) w_state_nx = HDR;
            end
            HDR, DATA: begin
                w_valid = 1'b1;
                w_dat   = (r_state == HDR) ? w_hdr : w_f_dat[r_gnt];
                if (w_loc_abort || w_far_abort) begin
                    w_skip[r_gnt] = 1'b1;
                    w_dec[r_gnt]  = 1'b1;
                    w_state_nx    = IDLE;
                end else if (mbox.mbox_w_ready) begin
                    if (r_state == HDR) begin
                        w_state_nx = DATA;
                    end else begin
                        w_pop[r_gnt] = 1'b1;
                        if (w_f_last[r_gnt]) w_state_nx = DONE;
                    end
                end
            end
            DONE: begin
                w_done        = 1'b1;
                w_sent[r_gnt] = 1'b1;
                w_dec[r_gnt]  = 1'b1;
                w_state_nx    = w_gnt_vld ? HDR : IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_rr_ptr    <= '0;
            r_w_abort   <= 1'b0;
            r_irq_abort <= '0;
            for (int c = 0; c < NCH; c++) r_seq[c] <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_gnt_vld && ((r_state == IDLE) || (r_state == DONE))) begin
                r_gnt    <= w_gnt_nx;
                r_rr_ptr <= (w_gnt_nx == CW'(NCH - 1)) ? '0 : w_gnt_nx + 1'b1;
            end
            if (r_state == DONE) begin
                r_seq[r_gnt] <= r_seq[r_gnt] + 1'b1;
            end
            r_w_abort   <= w_loc_abort;
            // OR merges a simultaneous local and far abort into one pulse.
            r_irq_abort <= s_abort | (w_far_abort ? w_gnt_oh : '0);
        end
    end

    assign mbox.mbox_w_dat   = w_dat;
    assign mbox.mbox_w_valid = w_valid;
    assign mbox.mbox_w_done  = w_done;
    assign mbox.mbox_w_abort = r_w_abort;
    assign irq_sent          = w_sent;
    assign irq_abort         = r_irq_abort;

endmodule
